// File: rtl/mult_8bit_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
//   DEFAULT_WIDTH : default operand width (product is twice this)
//   state_t       : controller states, 2-bit encoding
package mult_8bit_seq_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_8bit_seq_if.sv
// Request/result bundle between the ALU control FSM (master) and the
// multiplier (slave).
//   start   : master -> slave, operation request
//   a, b    : master -> slave, multiplicand / multiplier
//   busy    : slave -> master, iterating
//   done    : slave -> master, one-cycle result-valid pulse
//   product : slave -> master, 2*WIDTH-bit result
//
// Handshake: the slave samples start only when busy is low (IDLE or the
// DONE cycle); a and b are captured at that same edge and may change
// afterwards. busy is high for exactly WIDTH cycles, then done pulses for
// one cycle with product valid. start while busy is ignored. product holds
// its value until the next operation completes.
interface mult_8bit_seq_if
    import mult_8bit_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/mult_8bit_seq_add_nbit.sv
// Ripple-carry adder used for the per-iteration partial-sum add.
//   add_full : single full-adder cell (a_i, b_i, c_i -> s_o, c_o)
//   add_nbit : WIDTH-bit chain of add_full, carry-in tied to 0
//              a_i, b_i : WIDTH-bit addends
//              sum_o    : WIDTH-bit sum
//              cout_o   : carry out of the top cell
module add_full (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module add_nbit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        add_full u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (carry[i]),
            .s_o (sum_o[i]),
            .c_o (carry[i+1])
        );
    end

    assign cout_o = carry[WIDTH];
endmodule

// File: rtl/mult_8bit_seq.sv
// Sequential unsigned shift-and-add multiplier, one ripple add per cycle.
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset
//   bus     : mult_8bit_seq_if slave (start/a/b in, busy/done/product out)
//   state_o : current controller state (debug visibility)
// An accepted start runs exactly WIDTH iterations (no early-out), then
// pulses done for one cycle. product is a separate register written only on
// the final iteration, so partial accumulator values never appear on it.
module mult_8bit_seq
    import mult_8bit_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mult_8bit_seq_if.slave       bus,
    output state_t               state_o
);
    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    state_t               state_q;
    logic                 busy_q;
    logic                 done_q;
    logic [CW-1:0]        count_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   product_q;

    logic [WIDTH-1:0]     sum;
    logic                 cout;

    add_nbit #(.WIDTH(WIDTH)) u_add (
        .a_i    (acc_q[2*WIDTH-1:WIDTH]),
        .b_i    (mcand_q),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // Upper half accumulates partial sums; lower half starts as the
    // multiplier and is shifted out LSB-first. The carry is shifted in at
    // the top so the 2*WIDTH result is exact.
    always_comb begin
        acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        if (acc_q[0]) begin
            acc_d = {cout, sum, acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        mcand_q <= bus.a;
                        acc_q   <= {{WIDTH{1'b0}}, bus.b};
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_q   <= acc_d;
                    count_q <= count_q + ONE;
                    if (count_q == LAST) begin
                        product_q <= acc_d;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_mult_8bit_seq.sv
module tb_mult_8bit_seq;
    import mult_8bit_seq_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp_p;
    } vec_t;

    logic   clk;
    logic   rst_n;
    state_t dbg_state;

    mult_8bit_seq_if #(.WIDTH(W)) bus ();

    mult_8bit_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] held_prod;
    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned p;
        p = int'(a) * int'(b);
        return p[2*W-1:0];
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp_p);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        exp_q.push_back(exp_p);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
    endtask

    // Samples from busy cycle 1 until done; returns at the done-cycle negedge.
    task automatic finish_run(input string name, input int repulse_cycle);
        int n = 1;
        bit busy_ok = 1'b1;
        bit held_ok = 1'b1;
        logic [2*W-1:0] exp_p;
        while (!bus.done && n <= 20) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.product !== held_prod) held_ok = 1'b0;
            if (n == repulse_cycle) begin
                bus.start = 1'b1;
                bus.a     = 8'd2;
                bus.b     = 8'd2;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        check({name, "_latency"}, n, 9);
        check({name, "_busy_run"}, {31'd0, busy_ok}, 1);
        check({name, "_product_held"}, {31'd0, held_ok}, 1);
        check({name, "_busy_in_done"}, {31'd0, bus.busy}, 0);
        if (exp_q.size() == 0) begin
            check({name, "_sb_empty"}, 1, 0);
            exp_p = '0;
        end else begin
            exp_p = exp_q.pop_front();
        end
        check({name, "_product"}, {16'd0, bus.product}, {16'd0, exp_p});
        held_prod = exp_p;
    endtask

    task automatic idle_after(input string name);
        @(negedge clk);
        check({name, "_done_width"}, {31'd0, bus.done}, 0);
        check({name, "_idle_busy"}, {31'd0, bus.busy}, 0);
        check({name, "_idle_product"}, {16'd0, bus.product}, {16'd0, held_prod});
    endtask

    // ---------------- test ----------------
    vec_t vecs[8];

    initial begin
        logic [W-1:0] ra, rb;

        vecs[0] = '{8'd13,  8'd11,  16'h008F};
        vecs[1] = '{8'd255, 8'd255, 16'hFE01};
        vecs[2] = '{8'd0,   8'd200, 16'h0000};
        vecs[3] = '{8'd200, 8'd0,   16'h0000};
        vecs[4] = '{8'd1,   8'd255, 16'h00FF};
        vecs[5] = '{8'd255, 8'd1,   16'h00FF};
        vecs[6] = '{8'd128, 8'd2,   16'h0100};
        vecs[7] = '{8'd170, 8'd85,  16'h3872};

        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.a     = 8'd9;
        bus.b     = 8'd9;
        held_prod = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, bus.busy}, 0);
        check("reset_done", {31'd0, bus.done}, 0);
        check("reset_product", {16'd0, bus.product}, 0);
        check("reset_state", {30'd0, dbg_state}, 0);
        bus.start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            accept(vecs[i].a, vecs[i].b, vecs[i].exp_p);
            finish_run($sformatf("vec%0d", i), 0);
            idle_after($sformatf("vec%0d", i));
        end

        // Start re-pulsed while busy is ignored
        accept(8'd13, 8'd11, 16'h008F);
        finish_run("repulse", 3);
        idle_after("repulse");

        // Reset mid-run abandons the operation
        accept(8'd13, 8'd11, 16'h008F);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset_busy", {31'd0, bus.busy}, 0);
        check("midreset_done", {31'd0, bus.done}, 0);
        check("midreset_product", {16'd0, bus.product}, 0);
        void'(exp_q.pop_back());
        held_prod = '0;
        repeat (10) begin
            @(negedge clk);
            check("midreset_no_done", {31'd0, bus.done}, 0);
        end
        accept(8'd7, 8'd6, 16'h002A);
        finish_run("after_reset", 0);
        idle_after("after_reset");

        // Back-to-back accept from the DONE cycle
        accept(8'd13, 8'd11, 16'h008F);
        finish_run("b2b_first", 0);
        accept(8'd3, 8'd5, 16'h000F);
        check("b2b_busy_next", {31'd0, bus.busy}, 1);
        check("b2b_done_next", {31'd0, bus.done}, 0);
        finish_run("b2b_second", 0);
        idle_after("b2b_second");

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            accept(ra, rb, ref_mul(ra, rb));
            finish_run($sformatf("rand%0d", i), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0);
            if ($urandom_range(0, 1) == 1) idle_after($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
